// File: rtl/pid_uart_cmd_if.sv
// Byte-level handshake between the UART block and the command responder.
// rx side: the receiver presents a byte and raises rx_rdy.
// tx side: the responder strobes tx_send/tx_byte while the transmitter reports tx_rdy.
interface pid_uart_cmd_if;
  logic       rx_rdy;
  logic [7:0] rx_byte;
  logic       tx_rdy;
  logic       tx_send;
  logic [7:0] tx_byte;

  // UART side: drives received bytes and transmitter status
  modport master (output rx_rdy, rx_byte, tx_rdy, input tx_send, tx_byte);
  // Command responder side
  modport slave  (input rx_rdy, rx_byte, tx_rdy, output tx_send, tx_byte);
endinterface

// File: rtl/pid_uart_cmd.sv
// Framed command parser: writes/reads PID tuning registers and returns framed replies over UART.
// Latency: a byte is taken the cycle after the rx_rdy rise; the reply starts the cycle after EXEC.
// Backpressure: one reply byte per tx_rdy idle->busy->idle cycle; new rx bytes are dropped until the reply is handed off.
module pid_uart_cmd #(
  parameter int         TIMEOUT_CYC = 100_000,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15
) (
  input  logic                 clk_in,
  input  logic                 reset,
  pid_uart_cmd_if.slave        uart,
  input  logic [15:0]          meas,
  output logic [15:0]          kp,
  output logic [15:0]          ki,
  output logic [15:0]          kd,
  output logic [15:0]          setpoint,
  output logic                 cfg_update,
  output logic [7:0]           err_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {P_IDLE, P_A, P_H, P_L, P_C, P_EXEC, P_WAIT} p_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_BUSY, T_DONE} t_state_t;

  p_state_t      p_state, p_next;
  t_state_t      t_state, t_next;

  logic          rx_rdy_q;
  logic          byte_vld;
  logic [7:0]    byte_dat;
  logic [7:0]    addr_q, dhi_q, dlo_q, chk_q;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  logic [7:0]    rep [5];
  logic [2:0]    rep_len, rep_idx;
  logic          tx_active;
  logic          load_en;
  logic [2:0]    load_sel;

  logic          in_exec, is_rd, addr_ok, chk_ok, exec_ok;
  logic [15:0]   rd_val;

  // Edge-detect rx_rdy and latch the byte so it is consumed on the following cycle
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_rdy_q <= 1'b0;
      byte_vld <= 1'b0;
      byte_dat <= 8'h00;
    end else begin
      rx_rdy_q <= uart.rx_rdy;
      byte_vld <= uart.rx_rdy & ~rx_rdy_q;
      if (uart.rx_rdy & ~rx_rdy_q)
        byte_dat <= uart.rx_byte;
    end
  end

  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYC));
  assign tx_active = (rep_idx != rep_len) || (t_state != T_IDLE);

  // Decode the captured frame; only meaningful while in EXEC
  assign in_exec    = (p_state == P_EXEC);
  assign is_rd      = addr_q[7];
  assign chk_ok     = (chk_q == (addr_q ^ dhi_q ^ dlo_q));
  assign addr_ok    = (addr_q[6:3] == 4'd0) && (addr_q[2:0] <= 3'd4) &&
                      (is_rd || (addr_q[2:0] != 3'd4));
  assign exec_ok    = chk_ok && addr_ok;
  assign cfg_update = in_exec && exec_ok && !is_rd;

  // Read-back mux, sampled in EXEC
  always_comb begin
    rd_val = 16'h0000;
    case (addr_q[2:0])
      3'd0:    rd_val = kp;
      3'd1:    rd_val = ki;
      3'd2:    rd_val = kd;
      3'd3:    rd_val = setpoint;
      3'd4:    rd_val = meas;
      default: rd_val = 16'h0000;
    endcase
  end

  // Parser state register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) p_state <= P_IDLE;
    else       p_state <= p_next;
  end

  // Parser next state: hunt for SYNC, collect four bytes, execute, hold until reply is out
  always_comb begin
    p_next = p_state;
    case (p_state)
      P_IDLE: if (byte_vld && byte_dat == SYNC_BYTE) p_next = P_A;
      P_A:    if (byte_vld) p_next = P_H; else if (tmo_hit) p_next = P_IDLE;
      P_H:    if (byte_vld) p_next = P_L; else if (tmo_hit) p_next = P_IDLE;
      P_L:    if (byte_vld) p_next = P_C; else if (tmo_hit) p_next = P_IDLE;
      P_C:    if (byte_vld) p_next = P_EXEC; else if (tmo_hit) p_next = P_IDLE;
      P_EXEC: p_next = P_WAIT;
      P_WAIT: if (!tx_active) p_next = P_IDLE;
      default: p_next = P_IDLE;
    endcase
  end

  // Frame fields, inter-byte timeout, register file, error counter and reply buffer
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      addr_q    <= 8'h00;
      dhi_q     <= 8'h00;
      dlo_q     <= 8'h00;
      chk_q     <= 8'h00;
      tmo_cnt   <= '0;
      kp        <= 16'h0000;
      ki        <= 16'h0000;
      kd        <= 16'h0000;
      setpoint  <= 16'h0000;
      err_count <= 8'h00;
      rep_len   <= 3'd0;
      rep_idx   <= 3'd0;
      for (int i = 0; i < 5; i++) rep[i] <= 8'h00;
    end else begin
      if (byte_vld) begin
        case (p_state)
          P_A:     addr_q <= byte_dat;
          P_H:     dhi_q  <= byte_dat;
          P_L:     dlo_q  <= byte_dat;
          P_C:     chk_q  <= byte_dat;
          default: ;
        endcase
      end

      if (byte_vld || p_state == P_IDLE || p_state == P_EXEC || p_state == P_WAIT)
        tmo_cnt <= '0;
      else if (!tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (in_exec) begin
        rep_idx <= 3'd0;
        if (!exec_ok) begin
          rep[0]  <= NAK_BYTE;
          rep_len <= 3'd1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else if (is_rd) begin
          rep[0]  <= SYNC_BYTE;
          rep[1]  <= addr_q;
          rep[2]  <= rd_val[15:8];
          rep[3]  <= rd_val[7:0];
          rep[4]  <= addr_q ^ rd_val[15:8] ^ rd_val[7:0];
          rep_len <= 3'd5;
        end else begin
          case (addr_q[2:0])
            3'd0:    kp       <= {dhi_q, dlo_q};
            3'd1:    ki       <= {dhi_q, dlo_q};
            3'd2:    kd       <= {dhi_q, dlo_q};
            3'd3:    setpoint <= {dhi_q, dlo_q};
            default: ;
          endcase
          rep[0]  <= ACK_BYTE;
          rep[1]  <= addr_q;
          rep_len <= 3'd2;
        end
      end else if (t_state == T_DONE && uart.tx_rdy) begin
        rep_idx <= rep_idx + 3'd1;
      end
    end
  end

  // TX state register and the byte presented to the transmitter
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      t_state      <= T_IDLE;
      uart.tx_byte <= 8'h00;
    end else begin
      t_state <= t_next;
      if (load_en) uart.tx_byte <= rep[load_sel];
    end
  end

  // TX next state: strobe only into an idle transmitter, then track its busy/idle cycle
  always_comb begin
    t_next   = t_state;
    load_en  = 1'b0;
    load_sel = rep_idx;
    case (t_state)
      T_IDLE: if (rep_idx != rep_len && uart.tx_rdy) begin
        t_next  = T_SEND;
        load_en = 1'b1;
      end
      T_SEND: t_next = T_BUSY;
      T_BUSY: if (!uart.tx_rdy) t_next = T_DONE;
      T_DONE: if (uart.tx_rdy) begin
        if (rep_idx + 3'd1 != rep_len) begin
          t_next   = T_SEND;
          load_en  = 1'b1;
          load_sel = rep_idx + 3'd1;
        end else begin
          t_next = T_IDLE;
        end
      end
      default: t_next = T_IDLE;
    endcase
  end

  assign uart.tx_send = (t_state == T_SEND);

endmodule

// File: tb/tb_pid_uart_cmd.sv
// Bench for pid_uart_cmd: directed frames, a transmitter model with optional hold,
// and a scoreboard that checks every transmitted byte against an expected queue.
module tb_pid_uart_cmd;
  localparam int TMO = 200;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [15:0] meas;
  logic [15:0] kp, ki, kd, setpoint;
  logic        cfg_update;
  logic [7:0]  err_count;

  pid_uart_cmd_if u_if ();

  pid_uart_cmd #(.TIMEOUT_CYC(TMO)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .uart       (u_if),
    .meas       (meas),
    .kp         (kp),
    .ki         (ki),
    .kd         (kd),
    .setpoint   (setpoint),
    .cfg_update (cfg_update),
    .err_count  (err_count)
  );

  always #5 clk_in = ~clk_in;

  int         errors = 0;
  int         checks = 0;
  int         cfg_cnt = 0;
  logic       hold = 1'b0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Transmitter model: goes busy after each strobe, returns idle unless held
  initial begin
    u_if.tx_rdy = 1'b1;
    forever begin
      @(negedge clk_in);
      if (u_if.tx_send === 1'b1) begin
        u_if.tx_rdy = 1'b0;
        repeat (3) @(negedge clk_in);
        while (hold) @(negedge clk_in);
        u_if.tx_rdy = 1'b1;
      end
    end
  end

  // Monitor: compare each transmitted byte with the scoreboard, count cfg pulses
  always @(negedge clk_in) begin
    if (cfg_update === 1'b1) cfg_cnt++;
    if (u_if.tx_send === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected actual=%02h required=none", u_if.tx_byte);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (u_if.tx_byte !== e) begin
          errors++;
          $display("FAIL tx_byte actual=%02h required=%02h", u_if.tx_byte, e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in);
    u_if.rx_byte = b;
    u_if.rx_rdy  = 1'b1;
    repeat (2) @(negedge clk_in);
    u_if.rx_rdy  = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(h);
    send_byte(l);
    send_byte(c);
  endtask

  task automatic expect_bytes(input logic [39:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual=%0d required=0 bytes left", name, exp_q.size());
      exp_q.delete();
    end
    repeat (12) @(negedge clk_in);
  endtask

  initial begin
    reset        = 1'b1;
    meas         = 16'h0000;
    u_if.rx_rdy  = 1'b0;
    u_if.rx_byte = 8'h00;
    repeat (3) @(negedge clk_in);
    chk("rst_tx_send", {31'd0, u_if.tx_send}, 32'd0);
    chk("rst_tx_byte", {24'd0, u_if.tx_byte}, 32'd0);
    chk("rst_regs", {kp, ki} | {kd, setpoint}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    chk("rst_cfg", {31'd0, cfg_update}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk_in);

    // write ki
    expect_bytes(40'h06_01, 2);
    send_frame(8'h01, 8'h12, 8'h34, 8'h27);
    wait_drain("write_ki");
    chk("ki", {16'd0, ki}, 32'h1234);
    chk("cfg_after_write", cfg_cnt, 32'd1);

    // read ki back
    expect_bytes(40'hA5_81_12_34_A7, 5);
    send_frame(8'h81, 8'h00, 8'h00, 8'h81);
    wait_drain("read_ki");
    chk("cfg_after_read", cfg_cnt, 32'd1);

    // stray byte then bad checksum
    send_byte(8'h33);
    expect_bytes(40'h15, 1);
    send_frame(8'h00, 8'h00, 8'h05, 8'h00);
    wait_drain("bad_chk");
    chk("kp_unchanged", {16'd0, kp}, 32'd0);
    chk("err_1", {24'd0, err_count}, 32'd1);

    // read meas, then illegal writes/addresses
    meas = 16'hBEEF;
    expect_bytes(40'hA5_84_BE_EF_D5, 5);
    send_frame(8'h84, 8'h00, 8'h00, 8'h84);
    wait_drain("read_meas");
    expect_bytes(40'h15, 1);
    send_frame(8'h04, 8'h00, 8'h00, 8'h04);
    wait_drain("write_meas");
    chk("err_2", {24'd0, err_count}, 32'd2);
    expect_bytes(40'h15, 1);
    send_frame(8'h05, 8'h00, 8'h00, 8'h05);
    wait_drain("addr5");
    expect_bytes(40'h15, 1);
    send_frame(8'h08, 8'h00, 8'h00, 8'h08);
    wait_drain("addr_bits");
    chk("err_4", {24'd0, err_count}, 32'd4);
    chk("cfg_after_naks", cfg_cnt, 32'd1);

    // partial frame abandoned by timeout, then a full write
    send_byte(8'hA5);
    send_byte(8'h02);
    repeat (TMO + 50) @(negedge clk_in);
    expect_bytes(40'h06_02, 2);
    send_frame(8'h02, 8'h00, 8'h07, 8'h05);
    wait_drain("timeout_write");
    chk("kd", {16'd0, kd}, 32'h0007);
    chk("err_after_timeout", {24'd0, err_count}, 32'd4);
    chk("cfg_after_kd", cfg_cnt, 32'd2);

    // transmitter held busy mid-reply, then reset
    hold = 1'b1;
    expect_bytes(40'hA5, 1);
    send_frame(8'h81, 8'h00, 8'h00, 8'h81);
    repeat (60) @(negedge clk_in);
    chk("held_pending", exp_q.size(), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("rst2_tx_send", {31'd0, u_if.tx_send}, 32'd0);
    chk("rst2_regs", {kp, ki} | {kd, setpoint}, 32'd0);
    chk("rst2_err", {24'd0, err_count}, 32'd0);
    reset = 1'b0;
    hold  = 1'b0;
    repeat (10) @(negedge clk_in);
    expect_bytes(40'h06_03, 2);
    send_frame(8'h03, 8'hAB, 8'hCD, 8'h65);
    wait_drain("post_reset_write");
    chk("setpoint", {16'd0, setpoint}, 32'hABCD);
    chk("ki_after_reset", {16'd0, ki}, 32'd0);
    chk("cfg_final", cfg_cnt, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
